regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback requesters: ALU and MEM (load data).

---
 rtl/regfile_wb_pkg.sv | 22 ++
 rtl/wb_skid_buffer.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package regfile_wb_pkg;

  localparam int DATA_LENGTH = 64;
  localparam int ADDRESS     = 5;

  // x31 reads as zero; writes to it are consumed but never reach the regfile.
  localparam logic [ADDRESS-1:0] XZR = 5'd31;

  typedef struct packed {
    logic [ADDRESS-1:0]     rd;
    logic [DATA_LENGTH-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

endpackage

// File: rtl/wb_skid_buffer.sv
// One-entry writeback holding buffer with a valid/ready handshake.
// Latency: captured entry is visible on o_req the cycle after the transfer edge.
// Backpressure: o_ready = !full || granted, so a granted entry is refilled in the same cycle.
//
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   i_valid      requester has a writeback to hand over
//   o_ready      buffer accepts this cycle
//   i_req        rd/data, sampled only on a transfer
//   i_grant      arbiter picked this buffer; entry leaves at the next edge
//   o_full       buffer holds an entry
//   o_req        held rd/data
//   o_capture    transfer happens at the next edge
module wb_skid_buffer
  import regfile_wb_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_valid,
  output logic    o_ready,
  input  wb_req_t i_req,
  input  logic    i_grant,
  output logic    o_full,
  output wb_req_t o_req,
  output logic    o_capture
);

  logic    r_full;
  wb_req_t r_req;
  logic    w_capture;

  assign o_ready   = !r_full || i_grant;
  assign w_capture = i_valid && o_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_req  <= '0;
    end else if (w_capture) begin
      r_full <= 1'b1;
      r_req  <= i_req;
    end else if (i_grant) begin
      r_full <= 1'b0;
    end
  end

  assign o_full    = r_full;
  assign o_req     = r_req;
  assign o_capture = w_capture;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and MEM writeback via two holding buffers.
// Latency: accepted at edge E, regfile write strobe registered after E+1 (uncontested).
// Backpressure: per-source ready drops only while its buffer is full and not granted.
//
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   alu_valid/ready/rd/data       ALU writeback handshake
//   mem_valid/ready/rd/data       MEM (load) writeback handshake
//   RegWrite/WriteRegister/
//   WriteData                     registered regfile write port
//   busy_mask                     bit r set while a write to r is buffered or in the output stage
//
// Build option ARB_RR_EN: when defined, contested cycles use round-robin;
// otherwise MEM has priority and the ALU is forced through after STARVE_LIMIT losses.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDRESS-1:0]     alu_rd,
  input  logic [DATA_LENGTH-1:0] alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDRESS-1:0]     mem_rd,
  input  logic [DATA_LENGTH-1:0] mem_data,
  output logic                   RegWrite,
  output logic [ADDRESS-1:0]     WriteRegister,
  output logic [DATA_LENGTH-1:0] WriteData,
  output logic [2**ADDRESS-1:0]  busy_mask
);

  wb_req_t w_alu_in, w_mem_in, w_alu_req, w_mem_req, w_win;
  logic    w_alu_full, w_mem_full, w_alu_cap, w_mem_cap;
  logic    w_alu_grant, w_mem_grant, w_both;
  logic    w_grant_vld;
  wb_src_t w_grant_src;

  // Set when the ALU entry was captured before the MEM entry currently held.
  logic    r_alu_older;

  logic                   r_reg_write;
  logic [ADDRESS-1:0]     r_write_reg;
  logic [DATA_LENGTH-1:0] r_write_data;

  assign w_alu_in = '{rd: alu_rd, data: alu_data};
  assign w_mem_in = '{rd: mem_rd, data: mem_data};

  wb_skid_buffer u_alu_buf (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (alu_valid),
    .o_ready   (alu_ready),
    .i_req     (w_alu_in),
    .i_grant   (w_alu_grant),
    .o_full    (w_alu_full),
    .o_req     (w_alu_req),
    .o_capture (w_alu_cap)
  );

  wb_skid_buffer u_mem_buf (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (mem_valid),
    .o_ready   (mem_ready),
    .i_req     (w_mem_in),
    .i_grant   (w_mem_grant),
    .o_full    (w_mem_full),
    .o_req     (w_mem_req),
    .o_capture (w_mem_cap)
  );

  assign w_both = w_alu_full && w_mem_full;

`ifdef ARB_RR_EN
  wb_src_t r_rr_ptr;
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
  logic [CW-1:0] r_starve_cnt;
`endif

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_src = SRC_MEM;
    if (w_both) begin
      w_grant_vld = 1'b1;
      // Same destination: the older write must land first or the regfile ends up stale.
      if (w_alu_req.rd == w_mem_req.rd) begin
        w_grant_src = r_alu_older ? SRC_ALU : SRC_MEM;
      end else begin
`ifdef ARB_RR_EN
        w_grant_src = r_rr_ptr;
`else
        w_grant_src = (r_starve_cnt == STARVE_MAX) ? SRC_ALU : SRC_MEM;
`endif
      end
    end else if (w_alu_full) begin
      w_grant_vld = 1'b1;
      w_grant_src = SRC_ALU;
    end else if (w_mem_full) begin
      w_grant_vld = 1'b1;
      w_grant_src = SRC_MEM;
    end
  end

  assign w_alu_grant = w_grant_vld && (w_grant_src == SRC_ALU);
  assign w_mem_grant = w_grant_vld && (w_grant_src == SRC_MEM);
  assign w_win       = (w_grant_src == SRC_ALU) ? w_alu_req : w_mem_req;

  // A MEM capture makes the ALU entry older only if that ALU entry stays put;
  // a simultaneous capture (ALU empty or refilling) leaves MEM as the older one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu_older <= 1'b0;
    end else if (w_mem_cap) begin
      r_alu_older <= w_alu_full && !w_alu_grant;
    end else if (w_alu_cap) begin
      r_alu_older <= 1'b0;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= SRC_MEM;
    end else if (w_both) begin
      r_rr_ptr <= (w_grant_src == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end
  end
`else
  // Saturates at the limit: a same-rd age win for MEM can keep the ALU waiting past it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (!w_alu_full || w_alu_grant) begin
      r_starve_cnt <= '0;
    end else if (w_mem_grant && (r_starve_cnt != STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else if (w_grant_vld) begin
      r_reg_write  <= (w_win.rd != XZR);
      r_write_reg  <= w_win.rd;
      r_write_data <= w_win.data;
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  assign RegWrite      = r_reg_write;
  assign WriteRegister = r_write_reg;
  assign WriteData     = r_write_data;

  // Bit 31 stays clear: XZR never needs a read stall.
  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < 2**ADDRESS - 1; r++) begin
      busy_mask[r] = (w_alu_full && (w_alu_req.rd == ADDRESS'(r))) ||
                     (w_mem_full && (w_mem_req.rd == ADDRESS'(r))) ||
                     (r_reg_write && (r_write_reg == ADDRESS'(r)));
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a random phase,
// every cycle compared against a transaction-level model (capture timestamps, counters).
// Honours ARB_RR_EN for the expected arbitration order.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd;
  logic [63:0] alu_data, mem_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [31:0] busy_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .busy_mask     (busy_mask)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = ALU, 1 = MEM. Age is a global capture timestamp.
  bit          m_full [2];
  logic [4:0]  m_rd   [2];
  logic [63:0] m_data [2];
  int          m_seq  [2];
  int          seq_cnt;
  int          m_starve;
  int          m_ptr;
  bit          m_rw;
  logic [4:0]  m_wr;
  logic [63:0] m_wd;
  logic [63:0] rf [32];
  bit          acap, mcap;
  int          exp_seq [4];
  logic [4:0]  got_seq [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 1'b0; m_rd[i] = '0; m_data[i] = '0; m_seq[i] = 0;
    end
    seq_cnt = 0; m_starve = 0; m_ptr = 1;
    m_rw = 1'b0; m_wr = '0; m_wd = '0;
  endtask

  function automatic int model_grant();
    if (m_full[0] && m_full[1]) begin
      if (m_rd[0] == m_rd[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
`ifdef ARB_RR_EN
      return m_ptr;
`else
      return (m_starve >= LIMIT) ? 0 : 1;
`endif
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 0; r < 31; r++) begin
      for (int i = 0; i < 2; i++) if (m_full[i] && m_rd[i] == 5'(r)) b[r] = 1'b1;
      if (m_rw && m_wr == 5'(r)) b[r] = 1'b1;
    end
    return b;
  endfunction

  // One clock: check readies, advance model across the edge, check registered outputs.
  task automatic cycle();
    int g;
    g = model_grant();
    chk("alu_ready", alu_ready, (!m_full[0] || g == 0));
    chk("mem_ready", mem_ready, (!m_full[1] || g == 1));
    acap = alu_valid && (!m_full[0] || g == 0);
    mcap = mem_valid && (!m_full[1] || g == 1);
    @(posedge clk);
    if (g >= 0) begin
      m_rw = (m_rd[g] != 5'd31); m_wr = m_rd[g]; m_wd = m_data[g];
    end else begin
      m_rw = 1'b0;
    end
    if (!m_full[0] || g == 0) m_starve = 0;
    else if (g == 1) m_starve = m_starve + 1;
    if (m_full[0] && m_full[1]) m_ptr = 1 - g;
    if (g >= 0) m_full[g] = 1'b0;
    if (mcap) begin
      m_full[1] = 1'b1; m_rd[1] = mem_rd; m_data[1] = mem_data; m_seq[1] = seq_cnt; seq_cnt++;
    end
    if (acap) begin
      m_full[0] = 1'b1; m_rd[0] = alu_rd; m_data[0] = alu_data; m_seq[0] = seq_cnt; seq_cnt++;
    end
    #1;
    chk("RegWrite", RegWrite, m_rw);
    chk("WriteRegister", WriteRegister, m_wr);
    chk("WriteData", WriteData, m_wd);
    chk("busy_mask", busy_mask, model_busy());
    if (RegWrite) rf[WriteRegister] = WriteData;
  endtask

  function automatic logic [4:0] pick_rd();
    int v;
    v = $urandom_range(0, 8);
    return (v == 8) ? 5'd31 : 5'(v);
  endfunction

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_RegWrite", RegWrite, 1'b0);
    chk("rst_WriteRegister", WriteRegister, 5'd0);
    chk("rst_WriteData", WriteData, 64'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_mem_ready", mem_ready, 1'b1);
    reset = 1'b1;

    // ALU only, rd=5
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hA5;
    cycle();
    alu_valid = 1'b0;
    chk("t2_busy5_E", busy_mask[5], 1'b1);
    chk("t2_rw_E", RegWrite, 1'b0);
    cycle();
    chk("t2_rw", RegWrite, 1'b1);
    chk("t2_wr", WriteRegister, 5'd5);
    chk("t2_wd", WriteData, 64'hA5);
    chk("t2_busy5", busy_mask[5], 1'b1);
    cycle();
    chk("t2_busy5_ret", busy_mask[5], 1'b0);
    repeat (2) cycle();

    // Both streaming with distinct rd
`ifdef ARB_RR_EN
    exp_seq = '{10, 1, 11, 2};
`else
    exp_seq = '{10, 11, 12, 1};
`endif
    alu_valid = 1'b1; alu_rd = 5'd1;  alu_data = 64'h100;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 64'h200;
    for (int k = -1; k < 4; k++) begin
      cycle();
      if (k >= 0) begin
        got_seq[k] = WriteRegister;
        chk("t3_rw", RegWrite, 1'b1);
      end
      if (acap) begin alu_rd = alu_rd + 5'd1; alu_data = alu_data + 64'd1; end
      if (mcap) begin mem_rd = mem_rd + 5'd1; mem_data = mem_data + 64'd1; end
    end
    for (int k = 0; k < 4; k++) chk($sformatf("t3_grant%0d", k), got_seq[k], 5'(exp_seq[k]));
    alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (4) cycle();

    // Reset mid-traffic with both buffers full
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'h22;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'h44;
    cycle();
    #2 reset = 1'b0;
    #1;
    chk("t1_rw", RegWrite, 1'b0);
    chk("t1_busy", busy_mask, 32'd0);
    chk("t1_alu_ready", alu_ready, 1'b1);
    chk("t1_mem_ready", mem_ready, 1'b1);
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_rw_hold", RegWrite, 1'b0);
    reset = 1'b1;
    model_reset();

    // Same rd=7, ALU captured one cycle ahead of MEM
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h7A7A;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'h33;
    cycle();
    alu_valid = 1'b0;
    mem_rd = 5'd7; mem_data = 64'h7E7E;
    cycle();
    chk("t4_first_wr", WriteRegister, 5'd3);
    mem_valid = 1'b0;
    cycle();
    chk("t4_alu_wr", WriteRegister, 5'd7);
    chk("t4_alu_wd", WriteData, 64'h7A7A);
    cycle();
    chk("t4_mem_wr", WriteRegister, 5'd7);
    chk("t4_mem_wd", WriteData, 64'h7E7E);
    repeat (2) cycle();
    chk("t4_rf7", rf[7], 64'h7E7E);

    // MEM write to XZR
    mem_valid = 1'b1; mem_rd = 5'd31; mem_data = 64'hFF;
    cycle();
    mem_valid = 1'b0;
    chk("t5_busy31_buf", busy_mask[31], 1'b0);
    cycle();
    chk("t5_rw", RegWrite, 1'b0);
    chk("t5_wr", WriteRegister, 5'd31);
    chk("t5_wd", WriteData, 64'hFF);
    chk("t5_busy31", busy_mask[31], 1'b0);
    cycle();
    chk("t5_rw_after", RegWrite, 1'b0);

    // Random traffic; requesters hold valid/rd/data until accepted
    for (int n = 0; n < 2000; n++) begin
      if (!alu_valid || acap) begin
        alu_valid = ($urandom_range(0, 3) != 0); alu_rd = pick_rd(); alu_data = {$urandom, $urandom};
      end
      if (!mem_valid || mcap) begin
        mem_valid = ($urandom_range(0, 3) != 0); mem_rd = pick_rd(); mem_data = {$urandom, $urandom};
      end
      cycle();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (4) cycle();
    chk("drain_busy", busy_mask, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
